// File: rtl/ad9866_pkg.sv
// Shared types, frame helpers and the power-up register table for the AD9866 control port.
// Frames are 16 bits, {rw, addr[6:0], data[7:0]}, shifted MSB first.
package ad9866_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int GAIN_W  = 6;

  localparam int RW_BIT   = 15;
  localparam int ADDR_LSB = 8;
  localparam int DATA_LSB = 0;

  localparam logic [ADDR_W-1:0] GAIN_ADDR_DEFAULT = 7'h09;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_RST_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_XFER
  } seq_state_e;

  typedef enum logic [2:0] {
    SH_IDLE,
    SH_LOW,
    SH_HIGH,
    SH_TAIL,
    SH_GAP
  } sh_phase_e;

  typedef enum logic {
    OWN_GAIN,
    OWN_CMD
  } owner_e;

  function automatic logic [FRAME_W-1:0] make_frame(input logic              rw,
                                                    input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    return {rw, addr, data};
  endfunction

  // The two bits above the gain code select the RX PGA gain-write mode.
  function automatic logic [FRAME_W-1:0] gain_frame(input logic [ADDR_W-1:0] addr,
                                                    input logic [GAIN_W-1:0] gain);
    return make_frame(1'b0, addr, {2'b01, gain});
  endfunction

  function automatic logic [FRAME_W-1:0] init_table(input int unsigned idx);
    logic [FRAME_W-1:0] f;
    case (idx)
      0:       f = 16'h0180;
      1:       f = 16'h0200;
      2:       f = 16'h0300;
      3:       f = 16'h0436;
      4:       f = 16'h0500;
      5:       f = 16'h0600;
      6:       f = 16'h0708;
      7:       f = 16'h0E81;
      default: f = 16'h0000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ad9866_spi_shift.sv
// 16-bit SPI frame engine: sen_n framing, CLK_DIV half-period divider, bit counter,
// MSB-first transmit and receive shift registers, and the inter-frame sen_n high gap.
module ad9866_spi_shift
  import ad9866_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  input  logic               is_read,
  input  logic               sdo,
  output logic               ready,
  output logic               done,
  output logic [DATA_W-1:0]  rdata,
  output logic               sen_n,
  output logic               sclk,
  output logic               sdio
);

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(2 * CLK_DIV - 1);

  sh_phase_e          phase_q, phase_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         bit_q, bit_d;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic               sen_n_q, sen_n_d;
  logic               sclk_q, sclk_d;
  logic               half_end;

  assign half_end = (div_q == HALF_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    phase_d = phase_q;
    div_d   = div_q + DIV_W'(1);
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sen_n_d = sen_n_q;
    sclk_d  = sclk_q;
    done    = 1'b0;
    case (phase_q)
      SH_IDLE: begin
        div_d = '0;
        if (start) begin
          phase_d = SH_LOW;
          sen_n_d = 1'b0;
          bit_d   = '0;
          tx_d    = is_read ? {frame[FRAME_W-1:DATA_W], {DATA_W{1'b0}}} : frame;
        end
      end
      SH_LOW: begin
        if (half_end) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          phase_d = SH_HIGH;
          rx_d    = {rx_q[DATA_W-2:0], sdo};
        end
      end
      SH_HIGH: begin
        if (half_end) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 4'd15) begin
            phase_d = SH_TAIL;
            tx_d    = '0;
          end else begin
            phase_d = SH_LOW;
            bit_d   = bit_q + 4'd1;
            tx_d    = {tx_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      SH_TAIL: begin
        if (half_end) begin
          div_d   = '0;
          sen_n_d = 1'b1;
          done    = 1'b1;
          phase_d = SH_GAP;
        end
      end
      SH_GAP: begin
        // Holding off for a full SCLK period keeps sen_n high long enough between frames.
        if (div_q == GAP_LAST) begin
          div_d   = '0;
          phase_d = SH_IDLE;
        end
      end
      default: begin
        div_d   = '0;
        phase_d = SH_IDLE;
      end
    endcase
  end

  // NOTE: reset is sampled on the clock edge and every flop, including the shift registers, is cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= SH_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sen_n_q <= 1'b1;
      sclk_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
      phase_q <= phase_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sen_n_q <= sen_n_d;
      sclk_q  <= sclk_d;
    end
  end

  assign ready = (phase_q == SH_IDLE);
  assign rdata = rx_q;
  assign sen_n = sen_n_q;
  assign sclk  = sclk_q;
  assign sdio  = tx_q[FRAME_W-1];

endmodule

// File: rtl/ad9866_spi_sequencer.sv
// AD9866 control-port owner: hardware reset pulse, init table load, then round-robin
// sharing of the SPI frame engine between RX gain updates and host register commands.
module ad9866_spi_sequencer
  import ad9866_pkg::*;
#(
  parameter int                CLK_DIV    = 4,
  parameter int                RST_CYCLES = 1024,
  parameter int                NINIT      = 8,
  parameter logic [ADDR_W-1:0] GAIN_ADDR  = GAIN_ADDR_DEFAULT
) (
  input  logic              ad9866spiclk,
  input  logic              rst_n,
  input  logic              gain_req,
  input  logic [GAIN_W-1:0] gain,
  output logic              gain_ack,
  input  logic              cmd_req,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              cmd_ack,
  output logic [DATA_W-1:0] cmd_rdata,
  output logic              init_done,
  output logic              busy,
  output logic              ad9866_rst_n,
  output logic              ad9866_sen_n,
  output logic              ad9866_sclk,
  output logic              ad9866_sdio,
  input  logic              ad9866_sdo
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int IDX_W = $clog2(NINIT + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NINIT - 1);

  seq_state_e        state_q, state_d;
  logic [RST_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pin_q, pin_d;
  logic              init_done_q, init_done_d;
  logic              prefer_cmd_q, prefer_cmd_d;
  owner_e            owner_q, owner_d;
  logic              cur_rd_q, cur_rd_d;
  logic              gain_ack_q, gain_ack_d;
  logic              cmd_ack_q, cmd_ack_d;
  logic [DATA_W-1:0] cmd_rdata_q, cmd_rdata_d;

  logic               sh_start, sh_is_read, sh_ready, sh_done;
  logic [FRAME_W-1:0] sh_frame;
  logic [DATA_W-1:0]  sh_rdata;
  logic               pick_gain, pick_cmd;

  ad9866_spi_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk     (ad9866spiclk),
    .rst_n   (rst_n),
    .start   (sh_start),
    .frame   (sh_frame),
    .is_read (sh_is_read),
    .sdo     (ad9866_sdo),
    .ready   (sh_ready),
    .done    (sh_done),
    .rdata   (sh_rdata),
    .sen_n   (ad9866_sen_n),
    .sclk    (ad9866_sclk),
    .sdio    (ad9866_sdio)
  );

  // The round-robin flag only matters, and only flips, when both requesters contend.
  assign pick_gain = gain_req && (!cmd_req || !prefer_cmd_q);
  assign pick_cmd  = cmd_req && !pick_gain;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    pin_d        = pin_q;
    init_done_d  = init_done_q;
    prefer_cmd_d = prefer_cmd_q;
    owner_d      = owner_q;
    cur_rd_d     = cur_rd_q;
    gain_ack_d   = 1'b0;
    cmd_ack_d    = 1'b0;
    cmd_rdata_d  = cmd_rdata_q;
    sh_start     = 1'b0;
    sh_frame     = '0;
    sh_is_read   = 1'b0;
    case (state_q)
      ST_RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_RST_WAIT;
          cnt_d   = '0;
          pin_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + RST_W'(1);
        end
      end
      ST_RST_WAIT: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + RST_W'(1);
        end
      end
      ST_INIT: begin
        sh_frame = init_table(32'(idx_q));
        sh_start = sh_ready;
        if (sh_done) begin
          if (idx_q == IDX_LAST) begin
            state_d     = ST_IDLE;
            idx_d       = '0;
            init_done_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_IDLE: begin
        if (sh_ready && pick_gain) begin
          sh_start = 1'b1;
          sh_frame = gain_frame(GAIN_ADDR, gain);
          owner_d  = OWN_GAIN;
          cur_rd_d = 1'b0;
          state_d  = ST_XFER;
          if (cmd_req) prefer_cmd_d = 1'b1;
        end else if (sh_ready && pick_cmd) begin
          sh_start   = 1'b1;
          sh_frame   = make_frame(cmd_rw, cmd_addr, cmd_wdata);
          sh_is_read = cmd_rw;
          owner_d    = OWN_CMD;
          cur_rd_d   = cmd_rw;
          state_d    = ST_XFER;
          if (gain_req) prefer_cmd_d = 1'b0;
        end
      end
      ST_XFER: begin
        if (sh_done) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_GAIN) begin
            gain_ack_d = 1'b1;
          end else begin
            cmd_ack_d = 1'b1;
            if (cur_rd_q) cmd_rdata_d = sh_rdata;
          end
        end
      end
      default: state_d = ST_RST_HOLD;
    endcase
  end

  always_ff @(posedge ad9866spiclk) begin
    if (!rst_n) begin
      state_q      <= ST_RST_HOLD;
      cnt_q        <= '0;
      idx_q        <= '0;
      pin_q        <= 1'b0;
      init_done_q  <= 1'b0;
      prefer_cmd_q <= 1'b0;
      owner_q      <= OWN_GAIN;
      cur_rd_q     <= 1'b0;
      gain_ack_q   <= 1'b0;
      cmd_ack_q    <= 1'b0;
      cmd_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pin_q        <= pin_d;
      init_done_q  <= init_done_d;
      prefer_cmd_q <= prefer_cmd_d;
      owner_q      <= owner_d;
      cur_rd_q     <= cur_rd_d;
      gain_ack_q   <= gain_ack_d;
      cmd_ack_q    <= cmd_ack_d;
      cmd_rdata_q  <= cmd_rdata_d;
    end
  end

  assign gain_ack     = gain_ack_q;
  assign cmd_ack      = cmd_ack_q;
  assign cmd_rdata    = cmd_rdata_q;
  assign init_done    = init_done_q;
  assign busy         = (state_q != ST_IDLE);
  assign ad9866_rst_n = pin_q;

endmodule

// File: tb/tb_ad9866_spi_sequencer.sv
// Directed bench for ad9866_spi_sequencer: reset/init timing, gain and command frames,
// arbitration order, read-back, and reset in the middle of a frame.
module tb_ad9866_spi_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gain_req = 1'b0;
  logic [5:0] gain = '0;
  logic       gain_ack;
  logic       cmd_req = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_ack;
  logic [7:0] cmd_rdata;
  logic       init_done, busy;
  logic       ad9866_rst_n, ad9866_sen_n, ad9866_sclk, ad9866_sdio;
  logic       ad9866_sdo = 1'b0;

  always #5 clk = ~clk;

  ad9866_spi_sequencer dut (
    .ad9866spiclk (clk),
    .rst_n        (rst_n),
    .gain_req     (gain_req),
    .gain         (gain),
    .gain_ack     (gain_ack),
    .cmd_req      (cmd_req),
    .cmd_rw       (cmd_rw),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_ack      (cmd_ack),
    .cmd_rdata    (cmd_rdata),
    .init_done    (init_done),
    .busy         (busy),
    .ad9866_rst_n (ad9866_rst_n),
    .ad9866_sen_n (ad9866_sen_n),
    .ad9866_sclk  (ad9866_sclk),
    .ad9866_sdio  (ad9866_sdio),
    .ad9866_sdo   (ad9866_sdo)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  localparam logic [15:0] INIT_EXP [8] = '{16'h0180, 16'h0200, 16'h0300, 16'h0436,
                                          16'h0500, 16'h0600, 16'h0708, 16'h0E81};

  // Pin monitor and AD9866 readback model, evaluated on the falling clock edge.
  int          cyc = 0, rises = 0, period = 0, rise_t = 0;
  int          sen_rise_t = -1000, min_gap = 1000;
  int          gain_acks = 0, cmd_acks = 0, gain_ack_t = 0, cmd_ack_t = 0;
  logic        gain_ack_sen = 1'b0;
  logic [7:0]  rdata_at_ack = '0;
  logic [7:0]  sdo_byte = '0;
  logic [15:0] shreg = '0;
  logic        sclk_prev = 1'b0, sen_prev = 1'b1;
  logic [15:0] frames[$];
  int          frame_rises[$];

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (!ad9866_sen_n && sen_prev) begin
        rises = 0;
        shreg = '0;
        if (cyc - sen_rise_t < min_gap) min_gap = cyc - sen_rise_t;
      end
      if (!ad9866_sen_n && ad9866_sclk && !sclk_prev) begin
        shreg = {shreg[14:0], ad9866_sdio};
        if (rises == 1) period = cyc - rise_t;
        rise_t = cyc;
        rises++;
      end
      if (ad9866_sen_n && !sen_prev) begin
        frames.push_back(shreg);
        frame_rises.push_back(rises);
        sen_rise_t = cyc;
      end
      if (gain_ack) begin
        gain_acks++;
        gain_ack_t   = cyc;
        gain_ack_sen = ad9866_sen_n;
      end
      if (cmd_ack) begin
        cmd_acks++;
        cmd_ack_t    = cyc;
        rdata_at_ack = cmd_rdata;
      end
    end else begin
      sen_rise_t = cyc - 1000;
    end
    ad9866_sdo = (rises >= 8 && rises < 16) ? sdo_byte[15-rises] : 1'b0;
    sclk_prev  = ad9866_sclk;
    sen_prev   = ad9866_sen_n;
  end

  // Called right after rst_n is released; checks the reset pulse, wait and init frames.
  task automatic check_init(input string tag, input int acks_before);
    int n;
    bit seen;
    n = 0; seen = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk); #1; n++;
      if (ad9866_rst_n) seen = 1;
    end
    check({tag, "_rst_low_clks"}, n, 1024);
    n = 0; seen = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk); #1; n++;
      if (!ad9866_sen_n) seen = 1;
    end
    check({tag, "_wait_then_first_sen"}, n, 1025);
    seen = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk); #1;
      if (init_done) seen = 1;
    end
    check({tag, "_init_done_sen_high"}, {seen, ad9866_sen_n}, 2'b11);
    @(negedge clk); #1;
    check({tag, "_init_frame_count"}, frames.size(), 8);
    check({tag, "_no_ack_during_init"}, gain_acks, acks_before);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_init_%0d", tag, i),
            (i < frames.size()) ? {frame_rises[i][15:0], frames[i]} : 32'hDEAD_DEAD,
            {16'd16, INIT_EXP[i]});
    end
  endtask

  // Raise the selected requests, drop each one in the cycle after its ack.
  task automatic serve(input bit g, input bit c, input int budget);
    bit g_done, c_done;
    g_done = !g; c_done = !c;
    if (g) gain_req = 1'b1;
    if (c) cmd_req = 1'b1;
    for (int i = 0; i < budget && !(g_done && c_done); i++) begin
      @(negedge clk);
      if (g && gain_ack) begin gain_req = 1'b0; g_done = 1; end
      if (c && cmd_ack) begin cmd_req = 1'b0; c_done = 1; end
    end
    check("serve_acks_seen", {g_done, c_done}, 2'b11);
    gain_req = 1'b0;
    cmd_req  = 1'b0;
    repeat (20) @(negedge clk);
    #1;
  endtask

  int g_before, c_before;

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_pins", {ad9866_rst_n, ad9866_sen_n, ad9866_sclk, ad9866_sdio}, 4'b0100);
    check("reset_status", {gain_ack, cmd_ack, init_done, busy}, 4'b0001);
    check("reset_rdata", cmd_rdata, 8'h00);

    // 1: power-up sequence
    @(negedge clk);
    rst_n = 1'b1;
    check_init("boot", 0);
    check("boot_idle", {init_done, busy}, 2'b10);

    // 2: single gain write
    frames.delete(); frame_rises.delete();
    g_before = gain_acks;
    gain = 6'h2A;
    serve(1, 0, 400);
    check("gain_frame_count", frames.size(), 1);
    check("gain_frame", (frames.size() > 0) ? frames[0] : 16'hDEAD, 16'h096A);
    check("gain_rises", (frame_rises.size() > 0) ? frame_rises[0] : -1, 16);
    check("sclk_period", period, 8);
    check("gain_ack_once", gain_acks - g_before, 1);
    check("ack_with_sen_high", gain_ack_sen, 1'b1);

    // 3: simultaneous gain and command write; gain goes first
    frames.delete(); frame_rises.delete();
    gain = 6'h05; cmd_rw = 1'b0; cmd_addr = 7'h0B; cmd_wdata = 8'h33;
    serve(1, 1, 800);
    check("contend_frame_count", frames.size(), 2);
    check("contend_first_gain", (frames.size() > 0) ? frames[0] : 16'hDEAD, 16'h0945);
    check("contend_second_cmd", (frames.size() > 1) ? frames[1] : 16'hDEAD, 16'h0B33);
    check("ack_order", gain_ack_t < cmd_ack_t, 1'b1);
    check("ack_gap_ge_8", (cmd_ack_t - gain_ack_t) >= 8, 1'b1);
    check("sen_gap_ge_8", min_gap >= 8, 1'b1);
    check("write_keeps_rdata", cmd_rdata, 8'h00);

    // 4: register read with sdo returning 0x5C
    frames.delete(); frame_rises.delete();
    c_before = cmd_acks;
    sdo_byte = 8'h5C;
    cmd_rw = 1'b1; cmd_addr = 7'h0A; cmd_wdata = 8'hFF;
    serve(0, 1, 400);
    check("read_frame", (frames.size() > 0) ? frames[0] : 16'hDEAD, 16'h8A00);
    check("read_rdata_at_ack", rdata_at_ack, 8'h5C);
    check("read_rdata_held", cmd_rdata, 8'h5C);
    check("read_ack_once", cmd_acks - c_before, 1);

    // 5: reset in the middle of a gain frame; 6: gain request held through re-init
    gain = 6'h01;
    gain_req = 1'b1;
    begin
      bit mid;
      mid = 0;
      for (int i = 0; i < 400 && !mid; i++) begin
        @(negedge clk); #1;
        if (!ad9866_sen_n && rises >= 9) mid = 1;
      end
      check("midframe_reached", mid, 1'b1);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_pins", {ad9866_sen_n, ad9866_sclk, ad9866_rst_n}, 3'b100);
    check("midreset_status", {init_done, busy, gain_ack}, 3'b010);
    gain = 6'h15;
    repeat (3) @(negedge clk);
    g_before = gain_acks;
    frames.delete(); frame_rises.delete();
    rst_n = 1'b1;
    check_init("rerun", g_before);
    serve(1, 0, 400);
    check("held_gain_after_init_count", frames.size(), 9);
    check("held_gain_after_init", (frames.size() > 8) ? frames[8] : 16'hDEAD, 16'h0955);
    check("held_gain_ack_once", gain_acks - g_before, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
